vga_box_bounce: RTL and testbench
=================================

VGA_BOX_BOUNCE -- requirements
Module: vga_box_bounce

Interface
REQ-001 Parameters (name, default, meaning):
- H_ACT, 640, active pixels per line.
- V_ACT, 480, active lines per frame.
- BOX_W, 64, box width in pixels.
- BOX_H, 48, box height in lines.
- STEP, 2, pixels moved per frame on each axis.
- BORDER, 2, border thickness in pixels.
- BG_COLOR, 24'h000080, background colour.
REQ-002 Ports (name, direction, width, meaning):
- Clk25M, in, 1, pixel clock; the only clock.
- Rst, in, 1, reset; asynchronous, active-high.
- hcount, in, 10, active-area pixel column from the timing controller; 0 outside the active area.
- vcount, in, 10, active-area line from the timing controller; 0 outside the active area.
- VGA_BLK, in, 1, high inside the active display area.
- VGA_VS, in, 1, vertical sync; low during the frame-start sync lines.
- pause, in, 1, high freezes motion.
- data_in, out, 24, RGB pixel to the timing controller.
- frame_tick, out, 1, one-cycle pulse per frame.
- hit, out, 1, one-cycle pulse when a wall bounce occurs.

Function
REQ-003 The block SHALL register VGA_VS into vs_d every cycle.
REQ-004 Frame event: on a cycle where vs_d=1 and VGA_VS=0, the next clock edge SHALL set frame_tick=1 for exactly one cycle; frame_tick SHALL be 0 at all other times.
REQ-005 State registers:
- x, 10 bit, box left edge.
- y, 10 bit, box top edge.
- dir_x, 1 bit, 1 = moving right.
- dir_y, 1 bit, 1 = moving down.
- cidx, 3 bit, palette index.
REQ-006 x, y, dir_x, dir_y, cidx and hit SHALL update only on the edge that raises frame_tick, so the new position is visible from the frame_tick cycle onward. Updates occur in vertical blanking, so there is no tearing.
REQ-007 If pause=1 at the frame event, x, y, dir_x, dir_y and cidx SHALL hold, hit SHALL stay 0, and frame_tick SHALL still pulse.
REQ-008 X axis, moving right (dir_x=1):
- If x+STEP > H_ACT-BOX_W: x = H_ACT-BOX_W, dir_x = 0, bounce.
- Else: x = x+STEP.
REQ-009 X axis, moving left (dir_x=0):
- If x < STEP: x = 0, dir_x = 1, bounce.
- Else: x = x-STEP.
REQ-010 The Y axis SHALL behave as REQ-008/009, using y, dir_y, V_ACT and BOX_H.
REQ-011 All bound comparisons SHALL use 11-bit unsigned arithmetic, so no wrap-around occurs.
REQ-012 If either axis bounces at a frame event:
- hit SHALL be 1 for that single cycle.
- cidx SHALL increment by exactly 1, wrapping 7 to 0, even if both axes bounce in the same frame.
REQ-013 Palette, cidx 0..7: FF0000, 00FF00, 0000FF, FFFF00, 00FFFF, FF00FF, FF8000, 808080.
REQ-014 data_in SHALL be combinational from hcount, vcount, VGA_BLK and the registered state, with zero added latency, in this priority order:
- VGA_BLK=0: 0.
- Inside box, i.e. x<=hcount<x+BOX_W and y<=vcount<y+BOX_H, and within BORDER of any box edge: 24'hFFFFFF.
- Inside box otherwise: palette[cidx].
- Otherwise: BG_COLOR.

Reset
REQ-015 While Rst=1, independent of the clock:
- x = (H_ACT-BOX_W)/2 (288), y = (V_ACT-BOX_H)/2 (216).
- dir_x = 1, dir_y = 1, cidx = 0, vs_d = 1.
- frame_tick = 0, hit = 0, data_in = 0.
REQ-016 Rst asserted mid-frame or mid-pulse SHALL abort any pending update. The first frame event after release SHALL start from the reset values.

Verification
REQ-017 Reset, then 1 frame event with pause=0 -> frame_tick high 1 cycle, x=290, y=218, hit=0.
REQ-018 Defaults, 109 frame events -> y bounces at event 109 (y=432, dir_y=0, hit=1, cidx=1); at event 145 x=576, dir_x=0, hit=1, cidx=2.
REQ-019 Override BOX_W=208, 109 frame events -> x=432 and y=432 at event 109, both directions flip, single hit pulse, cidx=1 (not 2).
REQ-020 pause=1 across 10 frame events -> 10 frame_tick pulses, x, y and cidx unchanged, hit never asserted.
REQ-021 State x=288, y=216, VGA_BLK=1, with:
- (hcount,vcount)=(300,230) -> FF0000.
- (289,230) -> FFFFFF.
- (10,10) -> 000080.
- VGA_BLK=0 -> 000000.
REQ-022 Rst pulsed for 3 cycles at event 50 -> x=288, y=216 and cidx=0 immediately; next frame event gives x=290.

Source files
------------

// File: rtl/vga_box_bounce.sv
// Bouncing box overlay for a VGA timing controller: moves a bordered box once per frame
// during vertical blanking and paints it over a flat background.
module vga_box_bounce #(
  parameter int unsigned H_ACT    = 640,
  parameter int unsigned V_ACT    = 480,
  parameter int unsigned BOX_W    = 64,
  parameter int unsigned BOX_H    = 48,
  parameter int unsigned STEP     = 2,
  parameter int unsigned BORDER   = 2,
  parameter logic [23:0] BG_COLOR = 24'h000080
) (
  input  logic        Clk25M,
  input  logic        Rst,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        VGA_BLK,
  input  logic        VGA_VS,
  input  logic        pause,
  output logic [23:0] data_in,
  output logic        frame_tick,
  output logic        hit
);

  localparam logic [10:0] XMax   = 11'(H_ACT - BOX_W);
  localparam logic [10:0] YMax   = 11'(V_ACT - BOX_H);
  localparam logic [10:0] Step   = 11'(STEP);
  localparam logic [10:0] BoxW   = 11'(BOX_W);
  localparam logic [10:0] BoxH   = 11'(BOX_H);
  localparam logic [10:0] Border = 11'(BORDER);
  localparam logic [9:0]  XInit  = 10'((H_ACT - BOX_W) / 2);
  localparam logic [9:0]  YInit  = 10'((V_ACT - BOX_H) / 2);

  logic       vs_q, frame_tick_q, hit_q;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [2:0] cidx_q;
  logic       bounce_x, bounce_y, frame_ev, upd;
  logic [10:0] x_ext, y_ext;

  assign frame_ev = vs_q & ~VGA_VS;
  assign upd      = frame_ev & ~pause;
  assign x_ext    = {1'b0, x_q};
  assign y_ext    = {1'b0, y_q};

  always_comb begin
    x_d      = x_q;
    dir_x_d  = dir_x_q;
    bounce_x = 1'b0;
    if (dir_x_q) begin
      if (x_ext + Step > XMax) begin
        x_d      = XMax[9:0];
        dir_x_d  = 1'b0;
        bounce_x = 1'b1;
      end else begin
        x_d = 10'(x_ext + Step);
      end
    end else begin
      if (x_ext < Step) begin
        x_d      = '0;
        dir_x_d  = 1'b1;
        bounce_x = 1'b1;
      end else begin
        x_d = 10'(x_ext - Step);
      end
    end
  end

  always_comb begin
    y_d      = y_q;
    dir_y_d  = dir_y_q;
    bounce_y = 1'b0;
    if (dir_y_q) begin
      if (y_ext + Step > YMax) begin
        y_d      = YMax[9:0];
        dir_y_d  = 1'b0;
        bounce_y = 1'b1;
      end else begin
        y_d = 10'(y_ext + Step);
      end
    end else begin
      if (y_ext < Step) begin
        y_d      = '0;
        dir_y_d  = 1'b1;
        bounce_y = 1'b1;
      end else begin
        y_d = 10'(y_ext - Step);
      end
    end
  end

  always_ff @(posedge Clk25M or posedge Rst) begin
    if (Rst) begin
      vs_q         <= 1'b1;
      frame_tick_q <= 1'b0;
      hit_q        <= 1'b0;
      x_q          <= XInit;
      y_q          <= YInit;
      dir_x_q      <= 1'b1;
      dir_y_q      <= 1'b1;
      cidx_q       <= '0;
    end else begin
      vs_q         <= VGA_VS;
      frame_tick_q <= frame_ev;
      hit_q        <= upd & (bounce_x | bounce_y);
      if (upd) begin
        x_q     <= x_d;
        y_q     <= y_d;
        dir_x_q <= dir_x_d;
        dir_y_q <= dir_y_d;
        // A double-axis bounce still advances the palette only once.
        if (bounce_x | bounce_y) cidx_q <= cidx_q + 3'd1;
      end
    end
  end

  assign frame_tick = frame_tick_q;
  assign hit        = hit_q;

  logic [10:0] h_ext, v_ext;
  logic        in_box, on_border;
  logic [23:0] box_color;

  assign h_ext = {1'b0, hcount};
  assign v_ext = {1'b0, vcount};

  always_comb begin
    in_box = (h_ext >= x_ext) && (h_ext < x_ext + BoxW) &&
             (v_ext >= y_ext) && (v_ext < y_ext + BoxH);
    on_border = (h_ext < x_ext + Border) || (h_ext >= x_ext + BoxW - Border) ||
                (v_ext < y_ext + Border) || (v_ext >= y_ext + BoxH - Border);
    case (cidx_q)
      3'd0:    box_color = 24'hFF0000;
      3'd1:    box_color = 24'h00FF00;
      3'd2:    box_color = 24'h0000FF;
      3'd3:    box_color = 24'hFFFF00;
      3'd4:    box_color = 24'h00FFFF;
      3'd5:    box_color = 24'hFF00FF;
      3'd6:    box_color = 24'hFF8000;
      default: box_color = 24'h808080;
    endcase
    if (Rst || !VGA_BLK)    data_in = 24'h000000;
    else if (in_box && on_border) data_in = 24'hFFFFFF;
    else if (in_box)        data_in = box_color;
    else                    data_in = BG_COLOR;
  end

endmodule

// File: tb/tb_vga_box_bounce.sv
// Scoreboarded bench for vga_box_bounce: default instance plus a wide-box instance sharing
// the same stimulus; monitors check state at each frame_tick against queued expectations.
module tb_vga_box_bounce;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  hcount, vcount;
  logic        blk, vs, pause;
  logic [23:0] px1, px2;
  logic        tick1, tick2, hit1, hit2;

  always #5 clk = ~clk;

  vga_box_bounce dut1 (
    .Clk25M(clk), .Rst(rst), .hcount(hcount), .vcount(vcount), .VGA_BLK(blk),
    .VGA_VS(vs), .pause(pause), .data_in(px1), .frame_tick(tick1), .hit(hit1)
  );

  vga_box_bounce #(.BOX_W(208)) dut2 (
    .Clk25M(clk), .Rst(rst), .hcount(hcount), .vcount(vcount), .VGA_BLK(blk),
    .VGA_VS(vs), .pause(pause), .data_in(px2), .frame_tick(tick2), .hit(hit2)
  );

  typedef struct {
    int         ev;
    logic [9:0] x, y;
    logic       dx, dy;
    logic [2:0] c;
    logic       h;
  } exp_t;

  exp_t q1[$], q2[$];
  int checks = 0, failures = 0;
  int cnt1 = 0, cnt2 = 0, hits1 = 0, hits2 = 0;
  logic prev1 = 1'b0, prev2 = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(int ev, int x, int y, logic dx, logic dy, int c, logic h);
    exp_t e;
    e.ev = ev; e.x = 10'(x); e.y = 10'(y); e.dx = dx; e.dy = dy; e.c = 3'(c); e.h = h;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      cnt1 = 0;
      prev1 = 1'b0;
    end else begin
      if (hit1) cmp("d1_hit_with_tick", tick1, 1);
      if (tick1) begin
        cmp("d1_tick_width", prev1, 0);
        cnt1++;
        if (hit1) hits1++;
        if (q1.size() > 0 && q1[0].ev == cnt1) begin
          e = q1.pop_front();
          cmp($sformatf("d1_ev%0d_x", e.ev), dut1.x_q, e.x);
          cmp($sformatf("d1_ev%0d_y", e.ev), dut1.y_q, e.y);
          cmp($sformatf("d1_ev%0d_dx", e.ev), dut1.dir_x_q, e.dx);
          cmp($sformatf("d1_ev%0d_dy", e.ev), dut1.dir_y_q, e.dy);
          cmp($sformatf("d1_ev%0d_cidx", e.ev), dut1.cidx_q, e.c);
          cmp($sformatf("d1_ev%0d_hit", e.ev), hit1, e.h);
        end
      end
      prev1 = tick1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      cnt2 = 0;
      prev2 = 1'b0;
    end else begin
      if (hit2) cmp("d2_hit_with_tick", tick2, 1);
      if (tick2) begin
        cmp("d2_tick_width", prev2, 0);
        cnt2++;
        if (hit2) hits2++;
        if (q2.size() > 0 && q2[0].ev == cnt2) begin
          e = q2.pop_front();
          cmp($sformatf("d2_ev%0d_x", e.ev), dut2.x_q, e.x);
          cmp($sformatf("d2_ev%0d_y", e.ev), dut2.y_q, e.y);
          cmp($sformatf("d2_ev%0d_dx", e.ev), dut2.dir_x_q, e.dx);
          cmp($sformatf("d2_ev%0d_dy", e.ev), dut2.dir_y_q, e.dy);
          cmp($sformatf("d2_ev%0d_cidx", e.ev), dut2.cidx_q, e.c);
          cmp($sformatf("d2_ev%0d_hit", e.ev), hit2, e.h);
        end
      end
      prev2 = tick2;
    end
  end

  // One vsync low pulse of two lines followed by idle cycles.
  task automatic frame_event(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) vs = 1'b0;
      repeat (2) @(negedge clk);
      vs = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic probe(input string nm, input int h, input int v, input logic b,
                       input logic [23:0] e1, input logic [23:0] e2, input logic use2);
    hcount = 10'(h); vcount = 10'(v); blk = b;
    #1;
    cmp({nm, "_d1"}, px1, e1);
    if (use2) cmp({nm, "_d2"}, px2, e2);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; vs = 1'b1; pause = 1'b0; blk = 1'b1; hcount = 10'd300; vcount = 10'd230;
    #12;
    cmp("rst_x", dut1.x_q, 288);
    cmp("rst_y", dut1.y_q, 216);
    cmp("rst_dirs", {dut1.dir_x_q, dut1.dir_y_q}, 2'b11);
    cmp("rst_cidx", dut1.cidx_q, 0);
    cmp("rst_tick_hit", {tick1, hit1}, 2'b00);
    cmp("rst_data", px1, 24'h0);
    cmp("rst_x_wide", dut2.x_q, 216);
    @(negedge clk) rst = 1'b0;
    blk = 1'b0; hcount = '0; vcount = '0;
    @(negedge clk);

    q1.push_back(mk(1, 290, 218, 1, 1, 0, 0));
    q1.push_back(mk(108, 504, 432, 1, 1, 0, 0));
    q1.push_back(mk(109, 506, 432, 1, 0, 1, 1));
    q1.push_back(mk(110, 508, 430, 1, 0, 1, 0));
    q1.push_back(mk(144, 576, 362, 1, 0, 1, 0));
    q1.push_back(mk(145, 576, 360, 0, 0, 2, 1));
    q1.push_back(mk(146, 576, 360, 0, 0, 2, 0));
    q1.push_back(mk(155, 576, 360, 0, 0, 2, 0));
    q2.push_back(mk(1, 218, 218, 1, 1, 0, 0));
    q2.push_back(mk(109, 432, 432, 0, 0, 1, 1));
    q2.push_back(mk(110, 430, 430, 0, 0, 1, 0));

    frame_event(109);
    probe("pix_green", 520, 450, 1'b1, 24'h00FF00, 24'h00FF00, 1'b1);
    blk = 1'b0; hcount = '0; vcount = '0;
    frame_event(36);
    cmp("hits_d1_145", hits1, 2);
    cmp("hits_d2_145", hits2, 1);

    pause = 1'b1;
    frame_event(10);
    pause = 1'b0;
    @(negedge clk);
    cmp("ticks_d1_pause", cnt1, 155);
    cmp("hits_d1_pause", hits1, 2);
    cmp("pause_state", {dut1.x_q, dut1.y_q, dut1.cidx_q}, {10'd576, 10'd360, 3'd2});

    do_reset();
    probe("pix_fill", 300, 230, 1'b1, 24'hFF0000, 24'h0, 1'b0);
    probe("pix_border", 289, 230, 1'b1, 24'hFFFFFF, 24'h0, 1'b0);
    probe("pix_bg", 10, 10, 1'b1, 24'h000080, 24'h0, 1'b0);
    probe("pix_blank", 300, 230, 1'b0, 24'h000000, 24'h0, 1'b0);
    hcount = '0; vcount = '0;

    q1.push_back(mk(50, 388, 316, 1, 1, 0, 0));
    frame_event(50);
    // Reset lands between the vsync fall and the edge that would apply the update.
    @(negedge clk) vs = 1'b0;
    #2 rst = 1'b1;
    #1;
    cmp("abort_x", dut1.x_q, 288);
    cmp("abort_y", dut1.y_q, 216);
    cmp("abort_cidx", dut1.cidx_q, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0; vs = 1'b1;
    cmp("abort_tick", tick1, 0);
    repeat (3) @(negedge clk);
    cmp("abort_x_hold", dut1.x_q, 288);
    q1.push_back(mk(1, 290, 218, 1, 1, 0, 0));
    frame_event(1);
    repeat (2) @(negedge clk);
    cmp("after_abort_ticks", cnt1, 1);

    cmp("q1_drained", q1.size(), 0);
    cmp("q2_drained", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
